spi_word_sequencer: RTL and testbench

- Upstream feeder for the 24-bit SPI transmit controller (spiControl) in the IRS configuration path.
- Buffers 24-bit configuration words written by the control logic in a FIFO.
- Presents one word at a time to the SPI controller using its level handshake (load_data / done_send). Inserts a programmable idle gap between words.
- Runs on the 100 MHz system clock. Treats done_send as a signal that must be synchronised.

---
 rtl/spi_word_sequencer_if.sv | 32 +++
 rtl/spi_word_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_spi_word_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_word_sequencer_if.sv
// Bus bundle between the configuration control logic, the word sequencer
// and the 24-bit SPI transmit controller. The master side is the control
// logic plus the SPI controller; the slave side is the sequencer itself.
interface spi_word_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [23:0]       wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              clr_err;
  logic [23:0]       spi_data_in;
  logic              spi_load;
  logic              spi_done;
  logic              busy;
  logic [15:0]       words_sent;
  logic              err_timeout;

  modport master (
    output wr_en, wr_data, clr_err, spi_done,
    input  full, empty, level, overflow, spi_data_in, spi_load, busy,
           words_sent, err_timeout
  );

  modport slave (
    input  wr_en, wr_data, clr_err, spi_done,
    output full, empty, level, overflow, spi_data_in, spi_load, busy,
           words_sent, err_timeout
  );
endinterface

// File: rtl/spi_word_sequencer.sv
// spi_word_sequencer: FIFO-buffered feeder for the 24-bit SPI transmit
// controller. Words written by the control logic are queued, then handed to
// the controller one at a time over the load_data / done_send level
// handshake, with a programmable idle gap after every completed word.
// spi_done comes from another timing domain and is resynchronised here.
// Optional build macro SEQ_TIMEOUT_EN adds a handshake watchdog that drops a
// stuck word after TIMEOUT_CYCLES and raises the sticky err_timeout flag.
module spi_word_sequencer #(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int GAP_CYCLES     = 20,
  parameter int TIMEOUT_CYCLES = 4000
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_word_sequencer_if.slave  bus
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 2);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  // Parameter sanity checks at elaboration time.
  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("DEPTH must equal 2**ADDR_W");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, GAP} state_t;

  state_t                state_q, state_d;
  logic [23:0]           mem_q [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       level_q, level_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic [23:0]           data_q, data_d;
  logic [15:0]           sent_q, sent_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  done_s;
  logic                  push, pop;
  logic                  tmo_hit;

  assign done_s = sync_q[SYNC_STAGES-1];
  // full is sampled before any pop, so a write while full is always dropped.
  assign push   = bus.wr_en && !full_q;

`ifdef SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_q, err_d;

  assign tmo_hit = ((state_q == LOAD) || (state_q == RELEASE)) &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts cycles spent waiting on the handshake, restarts on any state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (state_d != state_q) begin
        tmo_q <= '0;
      end else if ((state_q == LOAD) || (state_q == RELEASE)) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_comb begin
    err_d = bus.clr_err ? 1'b0 : err_q;
    if (tmo_hit) begin
      err_d = 1'b1;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign tmo_hit         = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  // Two-flop (or deeper) synchroniser for the controller's done_send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.spi_done};
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // FIFO pointers, occupancy flags and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d    = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (!push && pop) begin
      level_d = level_q - LVL_ONE;
    end
    full_d     = (level_d == LVL_FULL);
    empty_d    = (level_d == '0);
    overflow_d = bus.clr_err ? 1'b0 : overflow_q;
    if (bus.wr_en && full_q) begin
      overflow_d = 1'b1;
    end
  end

  // Handshake FSM next-state: pop in IDLE, wait for done high, wait for done low, then gap.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sent_d  = sent_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (tmo_hit) begin
          state_d = IDLE;
        end else if (done_s) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (tmo_hit) begin
          state_d = IDLE;
        end else if (!done_s) begin
          sent_d  = sent_q + 16'd1;
          gap_d   = GAP_W'(GAP_CYCLES);
          state_d = GAP;
        end
      end
      GAP: begin
        // Exactly GAP_CYCLES cycles in GAP; a zero gap still spends the one entry cycle.
        if (gap_q <= GAP_W'(1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers; reset drops the FSM to IDLE and empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      data_q     <= '0;
      sent_q     <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
      sent_q     <= sent_d;
      gap_q      <= gap_d;
    end
  end

  // load_data drops as soon as the synchronised done is seen, without waiting
  // for the state register, so the release lands SYNC_STAGES edges after done.
  assign bus.spi_load    = (state_q == LOAD) && !done_s;
  assign bus.spi_data_in = data_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.words_sent  = sent_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.level       = level_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_spi_word_sequencer.sv
// Testbench for spi_word_sequencer: a behavioural SPI controller answers the
// load/done handshake, and every transmitted word is compared against the
// queue of words the bench itself wrote.
module tb_spi_word_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_word_sequencer_if #(.ADDR_W(4)) bus ();

  spi_word_sequencer #(
    .DEPTH(16), .ADDR_W(4), .SYNC_STAGES(2), .GAP_CYCLES(20), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [23:0] exp_q[$];
  logic [23:0] rx_q[$];
  bit ctl_en   = 1'b0;
  int ctl_delay_fixed = 0;
  int load_rise_cyc = 0, load_fall_cyc = 0, done_rise_cyc = 0, done_fall_cyc = 0;
  int min_gap = 1000000;
  bit have_fall = 1'b0;
  logic prev_load = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SPI controller: takes the word when load rises, answers with
  // done after a delay, and releases done a few cycles after load drops.
  initial begin : ctl_model
    int d;
    bus.spi_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ctl_en && bus.spi_load && !rst) begin
        rx_q.push_back(bus.spi_data_in);
        d = (ctl_delay_fixed > 0) ? ctl_delay_fixed : int'($urandom_range(2, 30));
        repeat (d) @(posedge clk);
        #1;
        bus.spi_done = 1'b1;
        done_rise_cyc = cyc;
        for (int k = 0; k < 50 && bus.spi_load; k++) begin @(posedge clk); #1; end
        repeat (3) @(posedge clk);
        #1;
        bus.spi_done = 1'b0;
        done_fall_cyc = cyc;
        have_fall = 1'b1;
      end
    end
  end

  // Records load edges and the smallest done-fall to next-load-rise distance.
  initial begin : monitor
    forever begin
      @(posedge clk); #1;
      if (bus.spi_load && !prev_load) begin
        load_rise_cyc = cyc;
        if (have_fall) begin
          if (cyc - done_fall_cyc < min_gap) min_gap = cyc - done_fall_cyc;
          have_fall = 1'b0;
        end
      end
      if (!bus.spi_load && prev_load) load_fall_cyc = cyc;
      prev_load = bus.spi_load;
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL global_timeout simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "global timeout");
  end

  function automatic int queue_diff();
    if (rx_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (rx_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic logic [23:0] rand_word();
    return 24'($urandom_range(0, 32'h00FF_FFFE));
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.clr_err = 1'b0;
    ctl_en = 1'b0; ctl_delay_fixed = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete(); rx_q.delete();
    have_fall = 1'b0;
  endtask

  task automatic push_word(input logic [23:0] w);
    bus.wr_en = 1'b1; bus.wr_data = w;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_sent(input int target, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      if (bus.words_sent == 16'(target)) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      if (!bus.busy) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.empty !== 1'b1) $display("FAIL rst_empty act=%b exp=1", bus.empty); else n_pass++;
    n_checks++; if (bus.full !== 1'b0) $display("FAIL rst_full act=%b exp=0", bus.full); else n_pass++;
    n_checks++; if (bus.level !== 5'd0) $display("FAIL rst_level act=%0d exp=0", bus.level); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL rst_overflow act=%b exp=0", bus.overflow); else n_pass++;
    n_checks++; if (bus.spi_load !== 1'b0) $display("FAIL rst_load act=%b exp=0", bus.spi_load); else n_pass++;
    n_checks++; if (bus.spi_data_in !== 24'h0) $display("FAIL rst_data act=%h exp=0", bus.spi_data_in); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy act=%b exp=0", bus.busy); else n_pass++;
    n_checks++; if (bus.words_sent !== 16'd0) $display("FAIL rst_sent act=%0d exp=0", bus.words_sent); else n_pass++;
    n_checks++; if (bus.err_timeout !== 1'b0) $display("FAIL rst_err act=%b exp=0", bus.err_timeout); else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    ctl_en = 1'b1; ctl_delay_fixed = 300;
    exp_q.push_back(24'hA5C3F0);
    push_word(24'hA5C3F0);
    @(posedge clk); #1;
    n_checks++; if (bus.spi_data_in !== 24'hA5C3F0) $display("FAIL single_data act=%h exp=a5c3f0", bus.spi_data_in); else n_pass++;
    n_checks++; if (bus.spi_load !== 1'b1) $display("FAIL single_load act=%b exp=1", bus.spi_load); else n_pass++;
    wait_sent(1, 1000, ok);
    n_checks++; if (!ok) $display("FAIL single_wait words_sent=%0d exp=1", bus.words_sent); else n_pass++;
    n_checks++; if (load_fall_cyc - done_rise_cyc != 2) $display("FAIL single_release_lat act=%0d exp=2", load_fall_cyc - done_rise_cyc); else n_pass++;
    n_checks++; if (bus.words_sent !== 16'd1) $display("FAIL single_sent act=%0d exp=1", bus.words_sent); else n_pass++;
    n_checks++; if (queue_diff() != -1) $display("FAIL single_rx diff=%0d rx_n=%0d exp_n=%0d", queue_diff(), rx_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (bus.spi_data_in !== 24'hA5C3F0) $display("FAIL single_hold act=%h exp=a5c3f0", bus.spi_data_in); else n_pass++;
  endtask

  task automatic test_burst();
    bit ok;
    logic [23:0] w;
    do_reset();
    // One lead word parks the FSM in LOAD so the following 16 fill the FIFO.
    w = rand_word(); exp_q.push_back(w); push_word(w);
    for (int i = 1; i <= 16; i++) begin
      w = 24'(i); exp_q.push_back(w); push_word(w);
    end
    n_checks++; if (bus.full !== 1'b1) $display("FAIL burst_full act=%b exp=1", bus.full); else n_pass++;
    n_checks++; if (bus.level !== 5'd16) $display("FAIL burst_level act=%0d exp=16", bus.level); else n_pass++;
    have_fall = 1'b0; min_gap = 1000000;
    ctl_en = 1'b1;
    wait_sent(17, 5000, ok);
    n_checks++; if (!ok) $display("FAIL burst_wait words_sent=%0d exp=17", bus.words_sent); else n_pass++;
    n_checks++; if (queue_diff() != -1) $display("FAIL burst_order diff=%0d rx_n=%0d exp_n=%0d", queue_diff(), rx_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (min_gap < 20) $display("FAIL burst_gap act=%0d exp>=20", min_gap); else n_pass++;
    n_checks++; if (bus.empty !== 1'b1) $display("FAIL burst_empty act=%b exp=1", bus.empty); else n_pass++;
  endtask

  task automatic test_overflow();
    bit ok;
    logic [23:0] w;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      w = rand_word(); exp_q.push_back(w); push_word(w);
    end
    n_checks++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0) $display("FAIL ovf_pre full=%b ovf=%b exp=1/0", bus.full, bus.overflow); else n_pass++;
    push_word(24'hFFFFFF);
    n_checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag act=%b exp=1", bus.overflow); else n_pass++;
    n_checks++; if (bus.level !== 5'd16) $display("FAIL ovf_level act=%0d exp=16", bus.level); else n_pass++;
    bus.clr_err = 1'b1; @(posedge clk); #1; bus.clr_err = 1'b0;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clear act=%b exp=0", bus.overflow); else n_pass++;
    ctl_en = 1'b1;
    wait_sent(17, 5000, ok);
    n_checks++; if (!ok) $display("FAIL ovf_wait words_sent=%0d exp=17", bus.words_sent); else n_pass++;
    n_checks++; if (queue_diff() != -1) $display("FAIL ovf_rx diff=%0d rx_n=%0d exp_n=%0d", queue_diff(), rx_q.size(), exp_q.size()); else n_pass++;
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [23:0] w;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      w = rand_word(); exp_q.push_back(w); push_word(w);
    end
    n_checks++; if (bus.level !== 5'd5) $display("FAIL simul_pre_level act=%0d exp=5", bus.level); else n_pass++;
    ctl_en = 1'b1; wait_sent(1, 500, ok); ctl_en = 1'b0;
    wait_idle(100, ok);
    n_checks++; if (!ok) $display("FAIL simul_idle1 busy=%b exp=0", bus.busy); else n_pass++;
    w = rand_word(); exp_q.push_back(w); push_word(w);
    n_checks++; if (bus.level !== 5'd5) $display("FAIL simul_wr_pop_level act=%0d exp=5", bus.level); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL simul_popped busy=%b exp=1", bus.busy); else n_pass++;
    for (int i = 0; i < 11; i++) begin
      w = rand_word(); exp_q.push_back(w); push_word(w);
    end
    n_checks++; if (bus.full !== 1'b1) $display("FAIL simul_full act=%b exp=1", bus.full); else n_pass++;
    ctl_en = 1'b1; wait_sent(2, 500, ok); ctl_en = 1'b0;
    wait_idle(100, ok);
    n_checks++; if (!ok) $display("FAIL simul_idle2 busy=%b exp=0", bus.busy); else n_pass++;
    push_word(24'hFFFFFF);
    n_checks++; if (bus.overflow !== 1'b1) $display("FAIL simul_full_ovf act=%b exp=1", bus.overflow); else n_pass++;
    n_checks++; if (bus.level !== 5'd15) $display("FAIL simul_full_level act=%0d exp=15", bus.level); else n_pass++;
    ctl_en = 1'b1;
    wait_sent(18, 5000, ok);
    n_checks++; if (queue_diff() != -1) $display("FAIL simul_rx diff=%0d rx_n=%0d exp_n=%0d", queue_diff(), rx_q.size(), exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [23:0] w;
    do_reset();
    push_word(rand_word());
    push_word(rand_word());
    n_checks++; if (bus.spi_load !== 1'b1) $display("FAIL rmid_pre_load act=%b exp=1", bus.spi_load); else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_checks++; if (bus.spi_load !== 1'b0) $display("FAIL rmid_async_load act=%b exp=0", bus.spi_load); else n_pass++;
    n_checks++; if (bus.level !== 5'd0 || bus.busy !== 1'b0) $display("FAIL rmid_async_state level=%0d busy=%b exp=0/0", bus.level, bus.busy); else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    n_checks++; if (bus.busy !== 1'b0 || bus.spi_load !== 1'b0) $display("FAIL rmid_quiet busy=%b load=%b exp=0/0", bus.busy, bus.spi_load); else n_pass++;
    n_checks++; if (bus.empty !== 1'b1 || bus.words_sent !== 16'd0) $display("FAIL rmid_empty empty=%b sent=%0d exp=1/0", bus.empty, bus.words_sent); else n_pass++;
    ctl_en = 1'b1;
    w = rand_word(); exp_q.push_back(w); push_word(w);
    wait_sent(1, 500, ok);
    n_checks++; if (queue_diff() != -1) $display("FAIL rmid_next diff=%0d rx_n=%0d exp_n=%0d", queue_diff(), rx_q.size(), exp_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    logic [23:0] w;
    do_reset();
    ctl_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 15)) begin @(posedge clk); #1; end
      for (int k = 0; k < 500 && bus.full; k++) begin @(posedge clk); #1; end
      w = rand_word(); exp_q.push_back(w); push_word(w);
    end
    wait_sent(40, 20000, ok);
    n_checks++; if (!ok) $display("FAIL rand_wait words_sent=%0d exp=40", bus.words_sent); else n_pass++;
    n_checks++; if (queue_diff() != -1) $display("FAIL rand_rx diff=%0d rx_n=%0d exp_n=%0d", queue_diff(), rx_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0 || bus.empty !== 1'b1) $display("FAIL rand_flags ovf=%b empty=%b exp=0/1", bus.overflow, bus.empty); else n_pass++;
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [23:0] w1, w2;
    bit ok;
    do_reset();
    w1 = rand_word(); w2 = rand_word();
    push_word(w1); push_word(w2);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (bus.err_timeout) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (!ok) $display("FAIL tmo_flag act=%b exp=1", bus.err_timeout); else n_pass++;
    n_checks++; if (cyc - load_rise_cyc != 100) $display("FAIL tmo_latency act=%0d exp=100", cyc - load_rise_cyc); else n_pass++;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.spi_load) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (!ok || bus.spi_data_in !== w2) $display("FAIL tmo_next act=%h exp=%h", bus.spi_data_in, w2); else n_pass++;
    n_checks++; if (bus.words_sent !== 16'd0) $display("FAIL tmo_sent act=%0d exp=0", bus.words_sent); else n_pass++;
  endtask
`endif

  initial begin : main
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.clr_err = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    test_random();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
